// File: rtl/fix72_to_flt_pkg.sv
// Shared constants and the packed double layout used by the fixed<->float converters.
package fix72_to_flt_pkg;

  localparam int FLT_BIAS   = 1023;
  localparam int FLT_FRAC_W = 52;
  localparam int FLT_EXP_W  = 11;
  localparam int FIX_W      = 72;

  typedef struct packed {
    logic                  sign;
    logic [FLT_EXP_W-1:0]  exp;
    logic [FLT_FRAC_W-1:0] frac;
  } flt64_t;

endpackage

// File: rtl/fix72_to_flt_if.sv
// Valid/ready bundle between the fixed-point producer, the converter and the float consumer.
interface fix72_to_flt_if;
  import fix72_to_flt_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [FIX_W-1:0] fx_in;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      flt_out;

  modport master (output in_valid, fx_in, out_ready,
                  input  in_ready, out_valid, flt_out);
  modport slave  (input  in_valid, fx_in, out_ready,
                  output in_ready, out_valid, flt_out);
endinterface

// File: rtl/fix72_to_flt_lzc72.sv
// Combinational 72-bit leading-zero counter with an all-zero flag.
module lzc72
  import fix72_to_flt_pkg::*;
(
  input  logic [FIX_W-1:0] d,
  output logic [6:0]       lzc,
  output logic             zero
);

  // Ascending scan so the highest set bit is the last one to win.
  always_comb begin
    lzc = 7'd0;
    for (int i = 0; i < FIX_W; i++)
      if (d[i]) lzc = 7'(FIX_W - 1 - i);
  end

  assign zero = ~|d;

endmodule

// File: rtl/fix72_to_flt.sv
// Signed 72-bit fixed point -> IEEE double, 3-stage valid/ready pipeline, RNE rounding.
module fix72_to_flt
  import fix72_to_flt_pkg::*;
#(
  parameter int FRAC_W = 52
) (
  input logic           clk,
  input logic           rst_n,
  fix72_to_flt_if.slave bus
);

  logic [3:1]       vld_pipe;
  logic             en;

  logic             s1_sign;
  logic [FIX_W-1:0] s1_mag;

  logic             s2_sign;
  logic             s2_zero;
  logic [FIX_W-1:0] s2_mag;
  logic [6:0]       s2_p;

  flt64_t           s3_res;

  logic [6:0]       lzc;
  logic             all_zero;

  logic [6:0]       sh_amt;
  logic [70:0]      sh;
  logic             guard, sticky, rnd;
  logic [52:0]      frac_r;
  logic [10:0]      exp_r;

  // Whole pipe moves as one; a bubble at the output lets it fill under backpressure.
  assign en            = !vld_pipe[3] || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_pipe[3];
  assign bus.flt_out   = s3_res;

  lzc72 u_lzc (.d(s1_mag), .lzc(lzc), .zero(all_zero));

  // Normalize so the leading one lands on bit 71 (dropped as the hidden bit), then round.
  always_comb begin
    sh_amt = 7'd71 - s2_p;
    sh     = 71'(s2_mag << sh_amt);
    guard  = sh[18];
    sticky = |sh[17:0];
    rnd    = guard && (sticky || sh[19]);
    frac_r = {1'b0, sh[70:19]} + {52'd0, rnd};
    exp_r  = 11'(s2_p) + 11'(FLT_BIAS - FRAC_W) + {10'd0, frac_r[52]};
  end

  // Valid shift register plus per-stage data, loaded only behind a valid token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_mag   <= '0;
      s2_p     <= '0;
      s3_res   <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[2:1], bus.in_valid};
      if (bus.in_valid) begin
        s1_sign <= bus.fx_in[FIX_W-1];
        // -2^71 negates to itself, which read unsigned is exactly 2^71.
        s1_mag  <= bus.fx_in[FIX_W-1] ? -bus.fx_in : bus.fx_in;
      end
      if (vld_pipe[1]) begin
        s2_sign <= s1_sign;
        s2_zero <= all_zero;
        s2_mag  <= s1_mag;
        s2_p    <= 7'd71 - lzc;
      end
      if (vld_pipe[2]) begin
        // Zero always packs as +0.0, never -0.0.
        if (s2_zero) s3_res <= '0;
        else         s3_res <= flt64_t'{sign: s2_sign, exp: exp_r, frac: frac_r[51:0]};
      end
    end
  end

endmodule

// File: tb/tb_fix72_to_flt.sv
// Bench for fix72_to_flt: table vectors, backpressure, mid-flight reset, random vs real-valued model.
module tb_fix72_to_flt;
  import fix72_to_flt_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             in_valid;
  logic [FIX_W-1:0] fx_in;
  logic             out_ready;

  fix72_to_flt_if a ();
  fix72_to_flt_if b ();

  assign a.in_valid  = in_valid;
  assign a.fx_in     = fx_in;
  assign a.out_ready = out_ready;
  assign b.in_valid  = in_valid;
  assign b.fx_in     = fx_in;
  assign b.out_ready = out_ready;

  fix72_to_flt #(.FRAC_W(52)) dut52 (.clk(clk), .rst_n(rst_n), .bus(a));
  fix72_to_flt #(.FRAC_W(71)) dut71 (.clk(clk), .rst_n(rst_n), .bus(b));

  typedef struct {
    logic [FIX_W-1:0] fx;
    logic [63:0]      exp;
  } vec_t;

  vec_t        vt[9];
  int          errors = 0;
  int          checks = 0;
  longint      cyc = 0;
  logic [63:0] q52[$];
  logic [63:0] q71[$];
  longint      qc[$];
  bit          check_lat = 1'b0;
  logic [63:0] cur52;
  bit          held = 1'b0;
  logic [63:0] held_val = '0;

  // Real-valued reference: one correctly rounded double add of two exact halves, then exact 2^-fw scale.
  function automatic logic [63:0] model(input logic [FIX_W-1:0] x, input int fw);
    logic [FIX_W-1:0] m;
    longint hi, lo;
    real r, sc;
    m = x[FIX_W-1] ? -x : x;
    if (m == '0) return 64'h0;
    hi = longint'(m[71:32]);
    lo = longint'(m[31:0]);
    r  = real'(hi) * 4294967296.0 + real'(lo);
    sc = 1.0;
    for (int i = 0; i < fw; i++) sc = sc / 2.0;
    r = r * sc;
    if (x[FIX_W-1]) r = -r;
    return $realtobits(r);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pop_cmp(input string nm, input logic [63:0] act, inout logic [63:0] q[$],
                         input bit use_lat);
    logic [63:0] e;
    longint c;
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_spurious: got %h expected no output", nm, act);
    end else begin
      e = q.pop_front();
      chk(nm, act, e);
      if (use_lat) begin
        c = qc.pop_front();
        if (check_lat) chk("latency", 64'(cyc - c), 64'd3);
      end
    end
  endtask

  // One clock: sample handshakes at the falling edge, then step past the rising edge.
  task automatic tick(output bit acc);
    @(negedge clk);
    acc = in_valid && a.in_ready;
    if (held) begin
      chk("stall_valid", 64'(a.out_valid), 64'd1);
      chk("stall_data", a.flt_out, held_val);
    end
    if (a.out_valid && !out_ready) chk("stall_in_ready", 64'(a.in_ready), 64'd0);
    held     = a.out_valid && !out_ready;
    held_val = a.flt_out;
    if (acc) begin
      q52.push_back(cur52);
      q71.push_back(model(fx_in, 71));
      qc.push_back(cyc);
    end
    if (a.out_valid && out_ready) pop_cmp("out52", a.flt_out, q52, 1'b1);
    if (b.out_valid && out_ready) pop_cmp("out71", b.flt_out, q71, 1'b0);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    in_valid = 1'b0;
    while ((q52.size() != 0 || q71.size() != 0) && n < 50) begin
      tick(acc);
      n++;
    end
    if (q52.size() != 0 || q71.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q52.size() + q71.size());
    end
  endtask

  function automatic logic [FIX_W-1:0] rnd72();
    logic [FIX_W-1:0] v;
    v = {8'($urandom), 32'($urandom), 32'($urandom)};
    return v >> $urandom_range(71, 0);
  endfunction

  initial begin
    bit acc;
    int i, k;
    logic [FIX_W-1:0] one;
    one = 72'd1;

    vt[0] = '{72'd0,                     64'h0000_0000_0000_0000};
    vt[1] = '{one << 52,                 64'h3FF0_0000_0000_0000};
    vt[2] = '{72'd0 - (one << 52),       64'hBFF0_0000_0000_0000};
    vt[3] = '{(one << 53) + 72'd1,       64'h4000_0000_0000_0000};
    vt[4] = '{(one << 53) + 72'd3,       64'h4000_0000_0000_0002};
    vt[5] = '{(one << 71) - 72'd1,       64'h4120_0000_0000_0000};
    vt[6] = '{one << 71,                 64'hC120_0000_0000_0000};
    vt[7] = '{72'd1,                     64'h3CB0_0000_0000_0000};
    vt[8] = '{72'd3 << 51,               64'h3FF8_0000_0000_0000};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; fx_in = '0; out_ready = 1'b1; cur52 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(a.out_valid), 64'd0);
    chk("reset_flt_out", a.flt_out, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick(acc);
    chk("post_reset_in_ready", 64'(a.in_ready), 64'd1);

    // Directed vectors, one at a time, latency checked
    check_lat = 1'b1;
    foreach (vt[j]) begin
      in_valid = 1'b1; fx_in = vt[j].fx; cur52 = vt[j].exp;
      tick(acc);
      chk("accept", 64'(acc), 64'd1);
      in_valid = 1'b0;
      drain();
    end
    // Same vectors back-to-back
    foreach (vt[j]) begin
      in_valid = 1'b1; fx_in = vt[j].fx; cur52 = vt[j].exp;
      tick(acc);
    end
    drain();
    check_lat = 1'b0;

    // Backpressure: 8 values streamed, out_ready low for cycles 5..9
    i = 0; k = 0;
    while (i < 8 && k < 100) begin
      in_valid  = 1'b1;
      if (k == 0 || acc) begin fx_in = rnd72(); cur52 = model(fx_in, 52); end
      out_ready = !(k >= 5 && k <= 9);
      tick(acc);
      if (acc) i++;
      k++;
    end
    out_ready = 1'b1;
    drain();

    // Reset with three operands in flight and a result parked at the output
    out_ready = 1'b0;
    i = 0;
    while (i < 3) begin
      in_valid = 1'b1; fx_in = rnd72(); cur52 = model(fx_in, 52);
      tick(acc);
      if (acc) i++;
    end
    in_valid = 1'b0;
    tick(acc); tick(acc);
    chk("pre_reset_out_valid", 64'(a.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_out_valid", 64'(a.out_valid), 64'd0);
    q52.delete(); q71.delete(); qc.delete(); held = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      tick(acc);
      chk("post_reset_idle", 64'(a.out_valid), 64'd0);
    end

    // Random traffic with random backpressure, both FRAC_W instances
    i = 0; k = 0;
    fx_in = rnd72(); cur52 = model(fx_in, 52);
    while (i < 10000 && k < 40000) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(9, 0) != 0);
        if ($urandom_range(3, 0) == 0) fx_in = {8'($urandom), 32'($urandom), 32'($urandom)};
        else                           fx_in = rnd72();
        cur52 = model(fx_in, 52);
      end
      out_ready = ($urandom_range(4, 0) != 0);
      tick(acc);
      if (acc) i++;
      k++;
    end
    if (i < 10000) begin
      checks++; errors++;
      $display("FAIL random_timeout: got %0d accepted expected 10000", i);
    end
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fix72_to_flt.md
# fix72_to_flt

Converts a signed 72-bit fixed-point operand back into an IEEE 754 double. It is the return path of the sampler's float-to-72-bit front end: it takes fixed-point results such as mu offsets and scaled samples and packs them into 64-bit doubles for the floating-point datapath. It is a three-stage valid/ready pipeline with round-to-nearest-even, and it stalls on downstream backpressure.

## Interface
- FRAC_W, default 52: number of fractional bits in the input. The input value is fx_in · 2^-FRAC_W. Legal range is 0..71.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fx_in is presented this cycle.
- in_ready  out  1  stage 1 can accept; a transfer occurs when in_valid && in_ready.
- fx_in  in  72  two's-complement fixed-point operand.
- out_valid  out  1  flt_out holds a result.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- flt_out  out  64  IEEE 754 double {sign, exp[10:0], frac[51:0]}.

## Operation
- Stage 1 (S1) captures the input:
  - sign = fx_in[71].
  - mag = |fx_in|, as a 72-bit unsigned value. The most negative input, -2^71, gives mag = 2^71 exactly.
- Stage 2 (S2) finds p, the index of the highest set bit of mag (0..71), using the leading-zero counter. It also sets a zero flag when mag = 0.
- Stage 3 (S3) normalizes, rounds and packs:
  - Left-align mag so that bit p sits at bit 71 of a shifted word.
  - frac = shifted[70:19]; guard = shifted[18]; sticky = |shifted[17:0].
  - When p ≤ 52, guard and sticky are 0, so the conversion is exact.
  - Round to nearest even: increment frac when guard && (sticky || frac[0]).
  - If frac overflows on that increment, frac = 0 and the exponent is incremented.
  - Exponent = p - FRAC_W + 1023. It is always in 952..1095, so denormals, infinities and NaN cannot occur.
  - Zero input gives flt_out = 64'h0 (+0.0), including the sign bit; -0 is never produced.
- No other rounding mode exists. There is no saturation and no exception flag.

## Timing
- Latency: 3 cycles from the input handshake to out_valid, when there is no stall.
- Throughput: 1 result per cycle.
- Global advance enable: en = !out_valid || out_ready. All three stages advance together when en = 1. in_ready = en.
- While stalled (out_valid && !out_ready):
  - flt_out and out_valid hold stable.
  - No stage changes.
  - in_ready = 0.
- Bubbles propagate as per-stage valid = 0. A bubble in S3 allows a fill even when out_ready = 0.
- Reset values: out_valid = 0, flt_out = 0, all stage valids = 0, all stage data = 0. in_ready = 1 from the first cycle after reset is released.
- Reset mid-operation: every in-flight operand is discarded and no partial result appears.
- Simultaneous input and output handshakes in the same cycle are legal and lose no data.

## Structure
- Shared package holds:
  - FLT_BIAS = 1023.
  - FLT_FRAC_W = 52.
  - FLT_EXP_W = 11.
  - FIX_W = 72.
  - A packed struct flt64_t {sign, exp, frac}, also used by the float-to-fixed front end.
- Sub-module lzc72: purely combinational. Takes 72 bits and returns a 7-bit leading-zero count plus an all-zero flag. p = 71 - lzc. Instantiated in S2.
- Target size: roughly 150-250 lines of RTL including lzc72.

## Test plan
All cases use FRAC_W = 52 unless noted.
- Sign and zero: 72'h0 -> 64'h0000_0000_0000_0000; 1<<52 -> 64'h3FF0_0000_0000_0000; -(1<<52) -> 64'hBFF0_0000_0000_0000. Each result appears exactly 3 cycles after acceptance.
- Rounding ties and up: 2^53+1 (tie, LSB even) -> 64'h4000_0000_0000_0000; 2^53+3 (tie, LSB odd) -> 64'h4000_0000_0000_0002.
- Rounding carry and extremes:
  - 2^71-1 -> rounds into the exponent -> 64'h4120_0000_0000_0000.
  - -2^71 -> 64'hC120_0000_0000_0000.
  - 1 -> 64'h3CB0_0000_0000_0000 (2^-52).
- Backpressure:
  - Stream 8 back-to-back values; hold out_ready = 0 for cycles 5-9.
  - in_ready drops within the same cycle as the stall.
  - No result is lost or duplicated; output order equals input order.
  - flt_out stays stable while stalled.
- Reset: assert rst_n low while 3 operands are in flight. out_valid drops to 0 immediately (asynchronously) and no stale result appears after release.
- Random: 10k random fx_in values compared bit-exactly against a real-valued round-to-nearest-even reference model, with FRAC_W = 52 and FRAC_W = 71.
